// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port.
// Data is favoured, but a pending fetch is guaranteed a slot after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [15:0]       if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [15:0]       dm_wdata,
  output logic [15:0]       dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              pipe_stall,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] dm_streak;
  logic [TW-1:0] tcnt;
  logic          grant_if, grant_dm, ack_done, tmo;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s == SW'(STARVE_LIMIT)) ? s : s + SW'(1);
  endfunction

  // A completion pulse blocks every grant for that cycle, giving one IDLE cycle
  // between accesses and hiding the just-served requester's still-high request.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    ack_done  = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (!if_valid && !dm_valid) begin
          if (dm_req && (!if_req || dm_streak != SW'(STARVE_LIMIT))) begin
            grant_dm  = 1'b1;
            state_nxt = BUSY_DM;
          end else if (if_req) begin
            grant_if  = 1'b1;
            state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack)
          ack_done = 1'b1;
        else if (tcnt == TW'(TIMEOUT - 1))
          tmo = 1'b1;
        if (ack_done || tmo)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dm_streak <= '0;
      tcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      state    <= state_nxt;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (grant_if) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
        dm_streak <= '0;
      end else if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_we    <= dm_we;
        mem_wdata <= dm_wdata;
        if (if_req)
          dm_streak <= streak_inc(dm_streak);
      end

      if (grant_if || grant_dm)
        tcnt <= '0;
      else if (state != IDLE && !ack_done && !tmo)
        tcnt <= tcnt + TW'(1);

      // A timed-out access still completes, returning zero data.
      if (ack_done || tmo) begin
        if (state == BUSY_IF) begin
          if_valid <= 1'b1;
          if_rdata <= tmo ? 16'h0000 : mem_rdata;
        end else begin
          dm_valid <= 1'b1;
          if (tmo)
            dm_rdata <= 16'h0000;
          else if (!mem_we)
            dm_rdata <= mem_rdata;
        end
      end

      if (tmo)
        err <= 1'b1;
    end
  end

  assign mem_req    = (state != IDLE);
  assign pipe_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory accesses and completions
// are queued as stimulus is issued and matched as the DUT produces them.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [7:0]  if_addr, dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        pipe_stall, err;

  int checks = 0;
  int failures = 0;

  logic no_ack = 1'b0;
  logic stray_ack = 1'b0;
  int   ack_dly = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_if[$];
  logic [15:0] exp_dm[$];
  logic [15:0] last_dm;

  mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pipe_stall(pipe_stall), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1120 + {8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns negedges until if_valid was seen.
  task automatic if_fetch(input logic [7:0] a, output int lat);
    if_req  = 1'b1;
    if_addr = a;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if_valid && lat < 64);
    chk("if_done", if_valid, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic [7:0] a, input logic we, input logic [15:0] wd,
                           output int lat);
    dm_req   = 1'b1;
    dm_addr  = a;
    dm_we    = we;
    dm_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dm_valid && lat < 64);
    chk("dm_done", dm_valid, 1'b1);
    dm_req = 1'b0;
  endtask

  // Memory: acks after ack_dly cycles of mem_req, returns mem_word(addr).
  initial begin
    int req_cyc;
    req_cyc   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ack   = !no_ack && (req_cyc == ack_dly);
        mem_rdata = mem_ack ? mem_word(mem_addr) : 16'hDEAD;
        req_cyc++;
      end else begin
        mem_ack   = stray_ack;
        mem_rdata = 16'h5A5A;
        req_cyc   = 0;
      end
    end
  end

  // Monitor: access scoreboard, completion scoreboard, stall function.
  initial begin
    acc_t cur;
    logic have_cur, prev_req, prev_iv, prev_dv;
    cur = '0;
    have_cur = 1'b0;
    prev_req = 1'b0;
    prev_iv  = 1'b0;
    prev_dv  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && !prev_req) begin
        if (exp_acc.size() == 0) chk("acc_unexpected", 1'b1, 1'b0);
        else begin
          cur = exp_acc.pop_front();
          have_cur = 1'b1;
        end
      end
      if (mem_req && have_cur) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", mem_we, cur.we);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (if_valid) begin
        chk("if_valid_pulse", prev_iv, 1'b0);
        if (exp_if.size() == 0) chk("if_valid_unexpected", 1'b1, 1'b0);
        else chk("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (dm_valid) begin
        chk("dm_valid_pulse", prev_dv, 1'b0);
        if (exp_dm.size() == 0) chk("dm_valid_unexpected", 1'b1, 1'b0);
        else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
      end
      chk("pipe_stall", pipe_stall, (if_req & ~if_valid) | (dm_req & ~dm_valid));
      prev_req = mem_req;
      prev_iv  = if_valid;
      prev_dv  = dm_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l1, l2;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    last_dm = 16'h0000;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_dm_valid", dm_valid, 1'b0);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_dm_rdata", dm_rdata, 16'h0000);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch at minimum latency
    exp_acc.push_back('{addr: 8'h03, we: 1'b0, wdata: 16'h0000});
    exp_if.push_back(16'h1123);
    if_fetch(8'h03, l1);
    chk("fetch_lat", l1, 2);

    // Ack while idle must produce nothing
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    #1;
    chk("idle_ack_mem_req", mem_req, 1'b0);
    @(negedge clk);

    // Simultaneous requests: data first, fetch after the idle cycle
    exp_acc.push_back('{addr: 8'h10, we: 1'b0, wdata: 16'h0000});
    exp_acc.push_back('{addr: 8'h20, we: 1'b0, wdata: 16'h0000});
    exp_dm.push_back(mem_word(8'h10));
    exp_if.push_back(mem_word(8'h20));
    last_dm = mem_word(8'h10);
    fork
      dm_access(8'h10, 1'b0, 16'h0000, l1);
      if_fetch(8'h20, l2);
    join
    chk("both_dm_lat", l1, 2);
    chk("both_if_lat", l2, 5);
    @(negedge clk);

    // Data stream against a held fetch: four data grants, then the fetch
    for (int i = 0; i < 4; i++)
      exp_acc.push_back('{addr: 8'h50 + 8'(i), we: 1'b0, wdata: 16'h0000});
    exp_acc.push_back('{addr: 8'h40, we: 1'b0, wdata: 16'h0000});
    exp_acc.push_back('{addr: 8'h54, we: 1'b0, wdata: 16'h0000});
    exp_acc.push_back('{addr: 8'h55, we: 1'b0, wdata: 16'h0000});
    for (int i = 0; i < 6; i++) exp_dm.push_back(mem_word(8'h50 + 8'(i)));
    exp_if.push_back(mem_word(8'h40));
    last_dm = mem_word(8'h55);
    fork
      begin
        int l;
        for (int i = 0; i < 6; i++) dm_access(8'h50 + 8'(i), 1'b0, 16'h0000, l);
      end
      if_fetch(8'h40, l2);
    join
    chk("starve_if_lat", l2, 14);
    @(negedge clk);

    // Store held stable while requester inputs change underneath
    ack_dly = 3;
    exp_acc.push_back('{addr: 8'h30, we: 1'b1, wdata: 16'hBEEF});
    exp_dm.push_back(last_dm);
    fork
      dm_access(8'h30, 1'b1, 16'hBEEF, l1);
      begin
        repeat (2) @(negedge clk);
        dm_addr = 8'hFF; dm_wdata = 16'h0000; dm_we = 1'b0;
      end
    join
    chk("store_lat", l1, 5);
    ack_dly = 0;
    @(negedge clk);

    // Timeout on a fetch
    no_ack = 1'b1;
    exp_acc.push_back('{addr: 8'h60, we: 1'b0, wdata: 16'h0000});
    exp_if.push_back(16'h0000);
    if_fetch(8'h60, l1);
    chk("tmo_lat", l1, TIMEOUT + 1);
    #1;
    chk("tmo_err", err, 1'b1);
    no_ack = 1'b0;
    @(negedge clk);
    exp_acc.push_back('{addr: 8'h31, we: 1'b1, wdata: 16'h1234});
    exp_dm.push_back(last_dm);
    dm_access(8'h31, 1'b1, 16'h1234, l1);
    chk("err_sticky", err, 1'b1);
    @(negedge clk);

    // Reset in the middle of a data access
    no_ack = 1'b1;
    exp_acc.push_back('{addr: 8'h70, we: 1'b0, wdata: 16'h0000});
    dm_req = 1'b1; dm_addr = 8'h70; dm_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_mem_req", mem_req, 1'b0);
    chk("rst_busy_mem_addr", mem_addr, 8'h00);
    chk("rst_busy_err", err, 1'b0);
    chk("rst_busy_dm_valid", dm_valid, 1'b0);
    dm_req = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", mem_req, 1'b0);
    exp_acc.push_back('{addr: 8'h05, we: 1'b0, wdata: 16'h0000});
    exp_if.push_back(mem_word(8'h05));
    if_fetch(8'h05, l1);
    chk("post_rst_fetch_lat", l1, 2);

    repeat (3) @(negedge clk);
    chk("acc_q_empty", exp_acc.size(), 0);
    chk("if_q_empty", exp_if.size(), 0);
    chk("dm_q_empty", exp_dm.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive data grants while a fetch is pending.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum BUSY cycles without mem_ack.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port if_req  input  1  fetch request, held high until if_valid.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port if_rdata  output  16  fetched instruction.
REQ-009 SHALL have port if_valid  output  1  one-cycle fetch-complete pulse.
REQ-010 SHALL have ports dm_req / dm_we  input  1 each  data request, held until dm_valid / write-enable.
REQ-011 SHALL have ports dm_addr  input  ADDR_W and dm_wdata  input  16  data address / store data.
REQ-012 SHALL have ports dm_rdata  output  16 and dm_valid  output  1  load data / one-cycle complete pulse.
REQ-013 SHALL have ports mem_req, mem_we  output  1 each and mem_addr  output  ADDR_W, mem_wdata  output  16  single shared memory port.
REQ-014 SHALL have ports mem_rdata  input  16 and mem_ack  input  1  memory read data / completion.
REQ-015 SHALL have port pipe_stall  output  1  pipeline hold.
REQ-016 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-018 In IDLE, a requester SHALL be ignored in any cycle its own valid is high.
REQ-019 In IDLE with only one eligible request, that requester SHALL be granted at the next edge.
REQ-020 In IDLE with both eligible, DM SHALL win unless dm_streak == STARVE_LIMIT, in which case IF SHALL win.
REQ-021 dm_streak SHALL increment (saturating at STARVE_LIMIT) on a DM grant while if_req is high, and SHALL clear on any IF grant.
REQ-022 On grant, address/we/wdata SHALL be latched; the winner's latched values drive mem_*; mem_req high for the entire BUSY state; IF grants force mem_we=0.
REQ-023 mem_addr/mem_we/mem_wdata SHALL be stable throughout BUSY regardless of requester input changes.
REQ-024 On an edge sampling mem_ack=1 in BUSY_x, state SHALL go to IDLE, x_valid SHALL be high the following cycle only, and x_rdata SHALL load mem_rdata (loads and fetches only; stores leave dm_rdata unchanged).
REQ-025 Minimum latency: request high at edge k -> mem_req high after edge k+1 -> ack sampled at edge k+2 -> valid high after edge k+2; no grant occurs in the cycle after a completion (one IDLE cycle).
REQ-026 A BUSY cycle counter SHALL clear on grant; when it reaches TIMEOUT without ack, state SHALL go to IDLE, pulse the pending valid with rdata 16'h0000, and set err until reset.
REQ-027 mem_ack while IDLE SHALL be ignored.
REQ-028 pipe_stall SHALL equal (if_req & ~if_valid) | (dm_req & ~dm_valid), combinationally.

Reset
REQ-029 reset high SHALL immediately force state IDLE, dm_streak 0, timeout counter 0, and outputs mem_req, mem_we, if_valid, dm_valid, err to 0 and mem_addr, mem_wdata, if_rdata, dm_rdata to 0.
REQ-030 reset asserted in BUSY SHALL abort the access with no valid pulse; the first grant after release SHALL follow REQ-019/020.

Verification
REQ-031 Fetch only: if_req=1, if_addr=8'h03, mem_ack one cycle after mem_req with mem_rdata=16'h1123 -> if_valid one cycle, if_rdata=16'h1123, mem_we=0.
REQ-032 Simultaneous if_req and dm_req (load, dm_addr=8'h10) -> DM granted first, IF granted on the IDLE following dm_valid; pipe_stall high until each valid.
REQ-033 Continuous dm_req with if_req held -> exactly STARVE_LIMIT (4) DM grants, then IF grant, streak cleared.
REQ-034 Store dm_we=1, dm_wdata=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF held until ack, dm_valid pulses, dm_rdata unchanged.
REQ-035 No mem_ack for 15 BUSY cycles -> return to IDLE, valid pulse with rdata 16'h0000, err=1 sticky until reset.
REQ-036 reset asserted mid-BUSY_DM -> mem_req drops at once, no dm_valid, FSM IDLE after release.
